// File: rtl/sine_dds_ctrl_if.sv
// Bus between the DDS phase controller, its upstream tick/control source,
// the quarter-wave sine ROM and the downstream sample consumer.
interface sine_dds_ctrl_if #(
    parameter int unsigned PHASE_W = 32,
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned DATA_W  = 16
);
    logic               tick;
    logic               run;
    logic [PHASE_W-1:0] fcw;
    logic               fcw_load;
    logic               rom_en;
    logic [ADDR_W-1:0]  rom_addr;
    logic [DATA_W-1:0]  rom_data;
    logic [DATA_W-1:0]  sample;
    logic               sample_valid;
    logic               cycle_wrap;

    // Environment side: drives control and ROM data, observes requests/samples.
    modport master (
        output tick, run, fcw, fcw_load, rom_data,
        input  rom_en, rom_addr, sample, sample_valid, cycle_wrap
    );

    // Controller side.
    modport slave (
        input  tick, run, fcw, fcw_load, rom_data,
        output rom_en, rom_addr, sample, sample_valid, cycle_wrap
    );
endinterface

// File: rtl/sine_dds_ctrl.sv
// Phase-accumulator DDS controller: issues quarter-wave ROM reads per accepted
// tick and rebuilds a full signed sine period via mirror/negate symmetry.
module sine_dds_ctrl #(
    parameter int unsigned PHASE_W = 32,
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned DATA_W  = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    sine_dds_ctrl_if.slave       io
);

    logic [PHASE_W-1:0] r_phase;
    logic [PHASE_W-1:0] r_inc;
    logic               r_rom_en;
    logic [ADDR_W-1:0]  r_rom_addr;
    logic               r_neg1;
    logic               r_wrap1;
    logic               r_v2;
    logic               r_neg2;
    logic               r_wrap2;
    logic [DATA_W-1:0]  r_sample;
    logic               r_sample_valid;
    logic               r_cycle_wrap;

    logic               w_accept;
    logic [1:0]         w_quad;
    logic [ADDR_W-1:0]  w_idx;
    logic [ADDR_W-1:0]  w_addr;
    logic [PHASE_W:0]   w_sum;
    logic [DATA_W-1:0]  w_signed;

    // Phase decode: top two bits pick the quadrant, next ADDR_W bits index the table.
    assign w_accept = io.tick & io.run;
    assign w_quad   = r_phase[PHASE_W-1 -: 2];
    assign w_idx    = r_phase[PHASE_W-3 -: ADDR_W];
    assign w_addr   = w_quad[0] ? ~w_idx : w_idx;
    assign w_sum    = {1'b0, r_phase} + {1'b0, r_inc};
    assign w_signed = r_neg2 ? (~io.rom_data + DATA_W'(1)) : io.rom_data;

    // Phase accumulator and increment register; a same-cycle tick uses the old increment.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_phase <= '0;
            r_inc   <= '0;
        end else begin
            if (io.fcw_load) r_inc <= io.fcw;
            if (w_accept)    r_phase <= w_sum[PHASE_W-1:0];
        end
    end

    // ROM request stage plus sign/wrap side-band for the read in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rom_en   <= 1'b0;
            r_rom_addr <= '0;
            r_neg1     <= 1'b0;
            r_wrap1    <= 1'b0;
        end else begin
            r_rom_en <= w_accept;
            if (w_accept) begin
                r_rom_addr <= w_addr;
                r_neg1     <= w_quad[1];
                r_wrap1    <= w_sum[PHASE_W];
            end
        end
    end

    // Side-band follows the ROM's registered read so it lines up with rom_data.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_v2           <= 1'b0;
            r_neg2         <= 1'b0;
            r_wrap2        <= 1'b0;
            r_sample       <= '0;
            r_sample_valid <= 1'b0;
            r_cycle_wrap   <= 1'b0;
        end else begin
            r_v2           <= r_rom_en;
            r_neg2         <= r_neg1;
            r_wrap2        <= r_wrap1;
            r_sample_valid <= r_v2;
            r_cycle_wrap   <= r_v2 & r_wrap2;
            if (r_v2) r_sample <= w_signed;
        end
    end

    assign io.rom_en       = r_rom_en;
    assign io.rom_addr     = r_rom_addr;
    assign io.sample       = r_sample;
    assign io.sample_valid = r_sample_valid;
    assign io.cycle_wrap   = r_cycle_wrap;

endmodule

// File: tb/tb_sine_dds_ctrl.sv
// Directed bench for sine_dds_ctrl with a 1-cycle-latency ROM model (data = addr*100).
module tb_sine_dds_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    sine_dds_ctrl_if #(.PHASE_W(32), .ADDR_W(6), .DATA_W(16)) bus ();

    sine_dds_ctrl #(.PHASE_W(32), .ADDR_W(6), .DATA_W(16)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .io    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.rom_en) bus.rom_data <= 16'(int'(bus.rom_addr) * 100);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic load_fcw(input logic [31:0] f);
        bus.fcw      = f;
        bus.fcw_load = 1'b1;
        step();
        bus.fcw_load = 1'b0;
    endtask

    // One isolated tick; captures the request at T+1 and the sample at T+3.
    task automatic one_tick(input logic ld, input logic [31:0] f,
                            output logic en, output logic [5:0] addr,
                            output logic sv, output logic [15:0] smp, output logic wr);
        bus.tick     = 1'b1;
        bus.fcw_load = ld;
        bus.fcw      = f;
        step();
        bus.tick     = 1'b0;
        bus.fcw_load = 1'b0;
        en   = bus.rom_en;
        addr = bus.rom_addr;
        step();
        step();
        sv  = bus.sample_valid;
        smp = bus.sample;
        wr  = bus.cycle_wrap;
        step();
    endtask

    function automatic logic [5:0] exp_addr(input int k);
        int qd;
        int j;
        qd = (k / 64) % 4;
        j  = k % 64;
        return 6'((qd % 2 == 1) ? 63 - j : j);
    endfunction

    function automatic logic [15:0] exp_sample(input int k);
        int a;
        a = int'(exp_addr(k)) * 100;
        if (((k / 64) % 4) >= 2) a = -a;
        return 16'(a);
    endfunction

    task automatic test_reset();
        logic en, sv, wr, seen;
        logic [5:0] addr;
        logic [15:0] smp;
        rst = 1'b1;
        #2;
        checks++;
        if ({bus.rom_en, bus.rom_addr, bus.sample, bus.sample_valid, bus.cycle_wrap} !== 25'd0) begin
            failures++;
            $display("FAIL reset_initial got=%h exp=0",
                     {bus.rom_en, bus.rom_addr, bus.sample, bus.sample_valid, bus.cycle_wrap});
        end
        step();
        rst = 1'b0;
        step();
        load_fcw(32'h0100_0000);
        for (int k = 0; k < 3; k++) one_tick(1'b0, 32'h0, en, addr, sv, smp, wr);
        checks++;
        if (bus.sample !== 16'd200) begin
            failures++;
            $display("FAIL reset_presample got=%0d exp=200", bus.sample);
        end
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.rom_en, bus.rom_addr, bus.sample, bus.sample_valid, bus.cycle_wrap} !== 25'd0) begin
            failures++;
            $display("FAIL reset_async got=%h exp=0",
                     {bus.rom_en, bus.rom_addr, bus.sample, bus.sample_valid, bus.cycle_wrap});
        end
        step();
        step();
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (bus.sample_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_valid got=%b exp=0", seen);
        end
    endtask

    task automatic test_sweep();
        logic en, sv, wr;
        logic [5:0] addr;
        logic [15:0] smp;
        do_reset();
        load_fcw(32'h0100_0000);
        for (int k = 0; k < 256; k++) begin
            one_tick(1'b0, 32'h0, en, addr, sv, smp, wr);
            checks++;
            if (en !== 1'b1 || addr !== exp_addr(k)) begin
                failures++;
                $display("FAIL sweep_addr k=%0d en=%b got=%0d exp=%0d", k, en, addr, exp_addr(k));
            end
            checks++;
            if (sv !== 1'b1 || smp !== exp_sample(k)) begin
                failures++;
                $display("FAIL sweep_sample k=%0d valid=%b got=%0d exp=%0d",
                         k, sv, $signed(smp), $signed(exp_sample(k)));
            end
            checks++;
            if (wr !== 1'(k == 255)) begin
                failures++;
                $display("FAIL sweep_wrap k=%0d got=%b exp=%b", k, wr, (k == 255));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic exp_en, exp_sv;
        do_reset();
        load_fcw(32'h0100_0000);
        bus.tick = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            step();
            bus.tick = (c < 4);
            exp_en = (c >= 1 && c <= 4);
            exp_sv = (c >= 3 && c <= 6);
            checks++;
            if (bus.rom_en !== exp_en || (exp_en && bus.rom_addr !== 6'(c - 1))) begin
                failures++;
                $display("FAIL b2b_rom c=%0d en=%b addr=%0d exp_en=%b exp_addr=%0d",
                         c, bus.rom_en, bus.rom_addr, exp_en, c - 1);
            end
            checks++;
            if (bus.sample_valid !== exp_sv || (exp_sv && bus.sample !== 16'((c - 3) * 100))) begin
                failures++;
                $display("FAIL b2b_sample c=%0d valid=%b got=%0d exp_valid=%b exp=%0d",
                         c, bus.sample_valid, bus.sample, exp_sv, (c - 3) * 100);
            end
        end
        bus.tick = 1'b0;
    endtask

    task automatic test_fcw_load();
        logic en, sv, wr;
        logic [5:0] addr;
        logic [15:0] smp;
        int exp_a [7] = '{0, 1, 2, 3, 4, 6, 8};
        do_reset();
        load_fcw(32'h0100_0000);
        for (int k = 0; k < 7; k++) begin
            one_tick(1'(k == 3), 32'h0200_0000, en, addr, sv, smp, wr);
            checks++;
            if (en !== 1'b1 || addr !== 6'(exp_a[k])) begin
                failures++;
                $display("FAIL fcw_load_addr k=%0d en=%b got=%0d exp=%0d", k, en, addr, exp_a[k]);
            end
        end
    endtask

    task automatic test_run_gating();
        logic en, sv, wr, seen;
        logic [5:0] addr;
        logic [15:0] smp;
        do_reset();
        load_fcw(32'h0100_0000);
        bus.run = 1'b1;
        for (int k = 0; k < 2; k++) one_tick(1'b0, 32'h0, en, addr, sv, smp, wr);
        bus.tick = 1'b1;
        step();
        bus.run = 1'b0;
        checks++;
        if (bus.rom_en !== 1'b1 || bus.rom_addr !== 6'd2) begin
            failures++;
            $display("FAIL run_last_req en=%b got=%0d exp=2", bus.rom_en, bus.rom_addr);
        end
        step();
        checks++;
        if (bus.rom_en !== 1'b0) begin
            failures++;
            $display("FAIL run_gated_en got=%b exp=0", bus.rom_en);
        end
        step();
        checks++;
        if (bus.sample_valid !== 1'b1 || bus.sample !== 16'd200) begin
            failures++;
            $display("FAIL run_inflight valid=%b got=%0d exp=200", bus.sample_valid, bus.sample);
        end
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (bus.rom_en !== 1'b0 || bus.sample_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL run_idle got=%b exp=0", seen);
        end
        bus.tick = 1'b0;
        bus.run  = 1'b1;
        one_tick(1'b0, 32'h0, en, addr, sv, smp, wr);
        checks++;
        if (en !== 1'b1 || addr !== 6'd3 || smp !== 16'd300) begin
            failures++;
            $display("FAIL run_resume en=%b addr=%0d sample=%0d exp_addr=3 exp_sample=300",
                     en, addr, smp);
        end
    endtask

    task automatic test_truncation();
        logic en, sv, wr;
        logic [5:0] addr;
        logic [15:0] smp;
        do_reset();
        load_fcw(32'h0080_0000);
        for (int k = 0; k < 512; k++) begin
            one_tick(1'b0, 32'h0, en, addr, sv, smp, wr);
            checks++;
            if (en !== 1'b1 || addr !== exp_addr(k / 2)) begin
                failures++;
                $display("FAIL trunc_addr k=%0d en=%b got=%0d exp=%0d", k, en, addr, exp_addr(k / 2));
            end
            checks++;
            if (wr !== 1'(k == 511)) begin
                failures++;
                $display("FAIL trunc_wrap k=%0d got=%b exp=%b", k, wr, (k == 511));
            end
        end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        bus.tick     = 1'b0;
        bus.run      = 1'b1;
        bus.fcw      = '0;
        bus.fcw_load = 1'b0;
        test_reset();
        test_sweep();
        test_back_to_back();
        test_fcw_load();
        test_run_gating();
        test_truncation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sine_dds_ctrl.md
# sine_dds_ctrl

Phase-accumulator controller sitting directly upstream of the sine `ROM`. It turns a sample-rate `tick` (from a `TickCounter`) and a frequency control word into ROM read requests (`en` + `address`). It reconstructs a full signed sine period from a quarter-wave ROM table using mirror/negate symmetry. It emits one signed sample per accepted tick with a valid strobe, for the downstream DAC/PWM stage.

## Interface
- `PHASE_W`, 32: phase accumulator and frequency-control-word width.
- `ADDR_W`, 6: ROM address width (quarter-wave table of 2^ADDR_W entries).
- `DATA_W`, 16: ROM word / output sample width.
- `clk`  in  1  system clock (100 MHz); all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `tick`  in  1  one-cycle sample strobe; may be high on consecutive cycles.
- `run`  in  1  when low, ticks are ignored and phase holds.
- `fcw`  in  PHASE_W  frequency control word (phase increment per tick).
- `fcw_load`  in  1  one-cycle strobe; captures `fcw` into the active increment register.
- `rom_en`  out  1  ROM read enable, connects to ROM `en`.
- `rom_addr`  out  ADDR_W  ROM address, connects to ROM `address`.
- `rom_data`  in  DATA_W  ROM `data`; valid one clock after the `rom_en` cycle. Unsigned magnitude, 0..2^(DATA_W-1)-1.
- `sample`  out  DATA_W  two's-complement sine sample.
- `sample_valid`  out  1  one-cycle strobe qualifying `sample`.
- `cycle_wrap`  out  1  one-cycle strobe, coincident with `sample_valid`, marking the sample whose phase add carried out of PHASE_W.

## Operation
- Reset values: phase = 0, active increment = 0, `rom_en` = 0, `rom_addr` = 0, `sample` = 0, `sample_valid` = 0, `cycle_wrap` = 0.
- Phase decode:
  - quadrant q = phase[PHASE_W-1 : PHASE_W-2].
  - index i = phase[PHASE_W-3 : PHASE_W-2-ADDR_W].
  - Lower bits are fractional and are truncated; there is no rounding.
- Address: `rom_addr` = q[0] ? ~i : i (mirror in quadrants 1 and 3).
- Sign: `sample` = q[1] ? -rom_data : +rom_data, computed in DATA_W two's complement. The ROM guarantees its top bit is 0, so negation never overflows.
- Accepted tick (`tick` & `run`) in cycle T. At the end of T:
  - `rom_en` <= 1 and `rom_addr` <= decoded address.
  - q[1] and the carry-out are stored in a pipeline stage.
  - phase <= phase + increment, modulo 2^PHASE_W.
- Without an accepted tick, `rom_en` <= 0. `rom_addr` holds its last value.
- The stored q[1] and carry advance one stage per clock alongside the ROM read, so each sample's sign and wrap bit stay aligned with its data.
- `fcw_load`:
  - Increment register <= `fcw` at the clock edge.
  - A tick accepted in the same cycle still uses the old increment; the new value applies from the next tick.
- `run` low: no new requests. Samples already in flight complete normally and still produce their `sample_valid`.
- Fully pipelined: one tick per clock is accepted. No backpressure; the downstream stage must accept every sample.
- Reset mid-pipeline clears the pipeline; in-flight samples are dropped and no `sample_valid` follows.

## Timing
- Cycle T (tick accepted) -> T+1: `rom_en` high, address valid.
- T+2: `rom_data` valid, because the ROM registers its read on the edge ending T+1.
- T+3: `sample` updated and `sample_valid` = 1 for exactly one cycle.
- Total latency is 3 clocks from tick to `sample_valid`.
- `sample` holds its value between strobes.
- `cycle_wrap` is high in the same cycle as the `sample_valid` of the carrying sample.

## Test plan
Common setup: defaults, a behavioural 1-cycle-latency ROM model with data = addr*100, and `tick` every 1000 clocks.

- **Reset:** assert `rst` mid-pipeline. Required: all outputs 0 immediately (asynchronous), and no `sample_valid` follows after release.
- **Full sweep:** `fcw` = 2^24, `run` = 1, 256 ticks. Required:
  - Addresses 0..63, then 63..0, then 0..63, then 63..0.
  - Samples 0..6300, then 6300..0, then 0..-6300, then -6300..0.
  - `cycle_wrap` on sample 256 only.
- **Latency / back-to-back:** `tick` high for 4 consecutive clocks, `fcw` = 2^24. Required: `rom_en` high for 4 clocks starting at T+1, and `sample_valid` high for 4 clocks starting at T+3, with samples 0, 100, 200, 300.
- **fcw_load timing:** `fcw_load` (`fcw` = 2^25) in the same cycle as tick k. Required: tick k steps the address by 1, and subsequent ticks step it by 2.
- **run gating:** drop `run` one cycle after a tick. Required: that sample still emerges at T+3, later ticks produce no `rom_en`, and phase is unchanged when `run` returns.
- **Fractional truncation:** `fcw` = 2^23. Required: each address is repeated twice and `cycle_wrap` appears after 512 ticks.
